// File: rtl/ikaopll_lite_if.sv
// ----------------------------------------------------------------------------
// ikaopll_lite_if
// CPU-side bus of the reduced OPLL sound block.
//   i_CS_n  chip select, active-low          (master -> slave)
//   i_WR_n  write strobe, active-low         (master -> slave)
//   i_A0    0 = address write, 1 = data write (master -> slave)
//   i_D     8-bit write data                 (master -> slave)
//   o_D     read data, always 8'h00          (slave -> master)
//   o_D_OE  read data output enable, always 0 (slave -> master)
// ----------------------------------------------------------------------------
interface ikaopll_lite_if;
    logic       i_CS_n;
    logic       i_WR_n;
    logic       i_A0;
    logic [7:0] i_D;
    logic [7:0] o_D;
    logic       o_D_OE;

    modport master (
        output i_CS_n, i_WR_n, i_A0, i_D,
        input  o_D, o_D_OE
    );

    modport slave (
        input  i_CS_n, i_WR_n, i_A0, i_D,
        output o_D, o_D_OE
    );
endinterface

// File: rtl/ikaopll_lite.sv
// ----------------------------------------------------------------------------
// ikaopll_lite
// Reduced YM2413-compatible sound block. A write-only CPU bus loads the OPLL
// register map; a 72-slot sample frame processes the nine channels in slots
// 0..8, each channel being a square wave of amplitude 15-VOL whose sign is the
// top bit of a 19-bit phase accumulator. Channels are mixed into a melody and
// a rhythm sum, published once per frame with a one-clock strobe.
//
// Ports
//   i_XIN_EMUCLK   sole clock (rising edge)
//   i_IC           synchronous reset, active-high
//   o_XOUT         inverted clock
//   i_phiM_PCEN_n  tick enable, active-low; state advances only on ticks
//   i_ALTPATCH_EN  alternate patch select (half-rectify source for INST!=0)
//   bus            CPU bus (slave modport): CS_n, WR_n, A0, D in; D, D_OE out
//   o_MO, o_RO     signed 9-bit melody / rhythm samples
//   o_MO_SAMPLE,
//   o_RO_SAMPLE    one-clock strobes when o_MO / o_RO update
// ----------------------------------------------------------------------------
module ikaopll_lite #(
    parameter bit FULLY_SYNCHRONOUS        = 1'b1,
    parameter bit FAST_RESET               = 1'b1,
    parameter bit ALTPATCH_CONFIG_MODE     = 1'b0,
    parameter bit USE_PIPELINED_MULTIPLIER = 1'b1
) (
    input  logic                i_XIN_EMUCLK,
    input  logic                i_IC,
    output logic                o_XOUT,
    input  logic                i_phiM_PCEN_n,
    input  logic                i_ALTPATCH_EN,
    ikaopll_lite_if.slave       bus,
    output logic signed [8:0]   o_MO,
    output logic signed [8:0]   o_RO,
    output logic                o_MO_SAMPLE,
    output logic                o_RO_SAMPLE
);
    localparam int         DATA_W    = 9;
    localparam logic [6:0] LAST_SLOT = 7'd71;
    localparam logic [6:0] LAST_CH   = 7'd8;
    // {CS_n, WR_n, A0, D} at rest: strobes inactive
    localparam logic [10:0] BUS_IDLE = {1'b1, 1'b1, 1'b0, 8'h00};

    // Square-wave output for one channel: positive half gives +amp, negative
    // half gives -amp, or silence when half-rectify is selected.
    function automatic logic signed [DATA_W-1:0] shape_wave(
        input logic [3:0] amp,
        input logic       neg,
        input logic       hr
    );
        logic signed [DATA_W-1:0] mag;
        mag = $signed({{(DATA_W-4){1'b0}}, amp});
        if (!neg)
            shape_wave = mag;
        else if (hr)
            shape_wave = '0;
        else
            shape_wave = -mag;
    endfunction

    function automatic logic addr_valid(input logic [7:0] a);
        addr_valid = (a <= 8'h07) || (a == 8'h0E) || (a == 8'h0F) ||
                     ((a >= 8'h10) && (a <= 8'h18)) ||
                     ((a >= 8'h20) && (a <= 8'h28)) ||
                     ((a >= 8'h30) && (a <= 8'h38));
    endfunction

    logic tick;
    logic rst;

    assign tick       = ~i_phiM_PCEN_n;
    // With slow reset, i_IC is only honoured on tick clocks.
    assign rst        = FAST_RESET ? i_IC : (i_IC & tick);
    assign o_XOUT     = ~i_XIN_EMUCLK;
    assign bus.o_D    = 8'h00;
    assign bus.o_D_OE = 1'b0;

    // ---------------- bus input synchronizer (runs every clock) ----------------
    logic [10:0] bus_s1_q;
    logic        cs_n_s;
    logic        wr_n_s;
    logic        a0_s;
    logic [7:0]  d_s;

    always_ff @(posedge i_XIN_EMUCLK) begin
        if (rst)
            bus_s1_q <= BUS_IDLE;
        else
            bus_s1_q <= {bus.i_CS_n, bus.i_WR_n, bus.i_A0, bus.i_D};
    end

    generate
        if (FULLY_SYNCHRONOUS) begin : g_sync2
            logic [10:0] bus_s2_q;
            always_ff @(posedge i_XIN_EMUCLK) begin
                if (rst)
                    bus_s2_q <= BUS_IDLE;
                else
                    bus_s2_q <= bus_s1_q;
            end
            assign {cs_n_s, wr_n_s, a0_s, d_s} = bus_s2_q;
        end else begin : g_sync1
            assign {cs_n_s, wr_n_s, a0_s, d_s} = bus_s1_q;
        end
    endgenerate

    // ---------------- bus write FSM: capture while strobed, commit on release ----------------
    typedef enum logic {
        BUS_WAIT = 1'b0,
        BUS_HELD = 1'b1
    } bus_state_t;

    bus_state_t bus_state_q;
    bus_state_t bus_state_d;
    logic       wr_act;
    logic       cap_en;
    logic       commit;
    logic       cap_a0_q;
    logic [7:0] cap_d_q;

    assign wr_act = ~cs_n_s & ~wr_n_s;

    always_ff @(posedge i_XIN_EMUCLK) begin
        if (rst)
            bus_state_q <= BUS_WAIT;
        else
            bus_state_q <= bus_state_d;
    end

    always_comb begin
        bus_state_d = bus_state_q;
        cap_en      = 1'b0;
        commit      = 1'b0;
        if (tick) begin
            case (bus_state_q)
                BUS_WAIT: begin
                    if (wr_act) begin
                        cap_en      = 1'b1;
                        bus_state_d = BUS_HELD;
                    end
                end
                BUS_HELD: begin
                    if (wr_act) begin
                        // the latest strobed cycle wins
                        cap_en = 1'b1;
                    end else begin
                        commit      = 1'b1;
                        bus_state_d = BUS_WAIT;
                    end
                end
                default: bus_state_d = BUS_WAIT;
            endcase
        end
    end

    always_ff @(posedge i_XIN_EMUCLK) begin
        if (rst) begin
            cap_a0_q <= 1'b0;
            cap_d_q  <= 8'h00;
        end else if (cap_en) begin
            cap_a0_q <= a0_s;
            cap_d_q  <= d_s;
        end
    end

    // ---------------- register file ----------------
    logic [7:0]      addr_q;
    logic [7:0][7:0] patch_q;     // 00-07
    logic [5:0]      rhy_q;       // 0E {R,BD,SD,TOM,CYM,HH}
    logic [7:0]      test_q;      // 0F
    logic [8:0][7:0] fnum_lo_q;   // 10-18
    logic [8:0][5:0] ctl_q;       // 20-28 {SUS,KEY,BLK[2:0],fnum[8]}
    logic [8:0][7:0] iv_q;        // 30-38 {INST,VOL}

    always_ff @(posedge i_XIN_EMUCLK) begin
        if (rst) begin
            addr_q    <= '0;
            patch_q   <= '0;
            rhy_q     <= '0;
            test_q    <= '0;
            fnum_lo_q <= '0;
            ctl_q     <= '0;
            iv_q      <= '0;
        end else if (commit) begin
            if (!cap_a0_q) begin
                addr_q <= cap_d_q;
            end else if (addr_valid(addr_q)) begin
                case (addr_q[7:4])
                    4'h0: begin
                        if (!addr_q[3])
                            patch_q[addr_q[2:0]] <= cap_d_q;
                        else if (addr_q[0])
                            test_q <= cap_d_q;
                        else
                            rhy_q <= cap_d_q[5:0];
                    end
                    4'h1:    fnum_lo_q[addr_q[3:0]] <= cap_d_q;
                    4'h2:    ctl_q[addr_q[3:0]]     <= cap_d_q[5:0];
                    4'h3:    iv_q[addr_q[3:0]]      <= cap_d_q;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- slot counter ----------------
    logic [6:0] cnt_q;
    logic [6:0] cnt_d;

    assign cnt_d = (cnt_q == LAST_SLOT) ? 7'd0 : cnt_q + 7'd1;

    always_ff @(posedge i_XIN_EMUCLK) begin
        if (rst)
            cnt_q <= '0;
        else if (tick)
            cnt_q <= cnt_d;
    end

    // ---------------- stage p0: per-channel phase update and amplitude ----------------
    logic [3:0]       ch;
    logic             proc_act;
    logic [8:0]       fnum;
    logic [2:0]       blk;
    logic             drum_key;
    logic             key;
    logic [18:0]      phase_inc;
    logic [18:0]      phase_new;
    logic [18:0]      phase_eff;
    logic [3:0]       amp;
    logic             alt_sel;
    logic             hr;
    logic             to_rhy;
    logic [8:0][18:0] phase_q;

    assign ch        = cnt_q[3:0];
    assign proc_act  = tick && (cnt_q <= LAST_CH);
    assign fnum      = {ctl_q[ch][0], fnum_lo_q[ch]};
    assign blk       = ctl_q[ch][3:1];
    assign phase_inc = {10'd0, fnum} << blk;
    assign phase_new = phase_q[ch] + phase_inc;

    always_comb begin
        drum_key = 1'b0;
        if (rhy_q[5]) begin
            case (ch)
                4'd6:    drum_key = rhy_q[4];
                4'd7:    drum_key = rhy_q[3] | rhy_q[0];
                4'd8:    drum_key = rhy_q[2] | rhy_q[1];
                default: drum_key = 1'b0;
            endcase
        end
    end

    assign key       = ctl_q[ch][4] | drum_key;
    // the wave is taken from the phase after this sample's advance
    assign phase_eff = key ? phase_new : phase_q[ch];
    assign amp       = key ? (4'd15 - iv_q[ch][3:0]) : 4'd0;
    assign alt_sel   = ALTPATCH_CONFIG_MODE ? test_q[7] : i_ALTPATCH_EN;
    assign hr        = (iv_q[ch][7:4] == 4'd0) ? patch_q[3][4] : alt_sel;
    assign to_rhy    = rhy_q[5] && (ch >= 4'd6);

    always_ff @(posedge i_XIN_EMUCLK) begin
        if (rst)
            phase_q <= '0;
        else if (proc_act && key)
            phase_q[ch] <= phase_new;
    end

    // ---------------- stage p1: amplitude / sign register ----------------
    logic [3:0] amp_p1_q;
    logic       neg_p1_q;
    logic       hr_p1_q;
    logic       vld_p1_q;
    logic       first_p1_q;
    logic       rhy_p1_q;

    always_ff @(posedge i_XIN_EMUCLK) begin
        if (rst) begin
            amp_p1_q   <= '0;
            neg_p1_q   <= 1'b0;
            hr_p1_q    <= 1'b0;
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
            rhy_p1_q   <= 1'b0;
        end else if (tick) begin
            amp_p1_q   <= amp;
            neg_p1_q   <= phase_eff[18];
            hr_p1_q    <= hr;
            vld_p1_q   <= proc_act;
            first_p1_q <= proc_act && (cnt_q == 7'd0);
            rhy_p1_q   <= to_rhy;
        end
    end

    // ---------------- stage p2: signed wave (optionally registered) ----------------
    logic signed [DATA_W-1:0] wave_p2;
    logic                     vld_p2;
    logic                     first_p2;
    logic                     rhy_p2;

    generate
        if (USE_PIPELINED_MULTIPLIER) begin : g_pipe
            logic signed [DATA_W-1:0] wave_p2_q;
            logic                     vld_p2_q;
            logic                     first_p2_q;
            logic                     rhy_p2_q;
            always_ff @(posedge i_XIN_EMUCLK) begin
                if (rst) begin
                    wave_p2_q  <= '0;
                    vld_p2_q   <= 1'b0;
                    first_p2_q <= 1'b0;
                    rhy_p2_q   <= 1'b0;
                end else if (tick) begin
                    wave_p2_q  <= shape_wave(amp_p1_q, neg_p1_q, hr_p1_q);
                    vld_p2_q   <= vld_p1_q;
                    first_p2_q <= first_p1_q;
                    rhy_p2_q   <= rhy_p1_q;
                end
            end
            assign wave_p2  = wave_p2_q;
            assign vld_p2   = vld_p2_q;
            assign first_p2 = first_p2_q;
            assign rhy_p2   = rhy_p2_q;
        end else begin : g_comb
            assign wave_p2  = shape_wave(amp_p1_q, neg_p1_q, hr_p1_q);
            assign vld_p2   = vld_p1_q;
            assign first_p2 = first_p1_q;
            assign rhy_p2   = rhy_p1_q;
        end
    endgenerate

    // ---------------- stage p3: mix accumulators and frame output ----------------
    logic signed [DATA_W-1:0] mo_acc_q;
    logic signed [DATA_W-1:0] ro_acc_q;
    logic signed [DATA_W-1:0] mo_q;
    logic signed [DATA_W-1:0] ro_q;
    logic                     smp_q;
    logic                     frame_end;

    assign frame_end = tick && (cnt_q == LAST_SLOT);

    // channel 0 (always melody) restarts both sums for the new frame
    always_ff @(posedge i_XIN_EMUCLK) begin
        if (rst) begin
            mo_acc_q <= '0;
            ro_acc_q <= '0;
        end else if (tick && vld_p2) begin
            if (first_p2) begin
                mo_acc_q <= wave_p2;
                ro_acc_q <= '0;
            end else if (rhy_p2) begin
                ro_acc_q <= ro_acc_q + wave_p2;
            end else begin
                mo_acc_q <= mo_acc_q + wave_p2;
            end
        end
    end

    // the strobe is refreshed every clock so that it stays one clock wide
    always_ff @(posedge i_XIN_EMUCLK) begin
        if (rst) begin
            mo_q  <= '0;
            ro_q  <= '0;
            smp_q <= 1'b0;
        end else begin
            smp_q <= frame_end;
            if (frame_end) begin
                mo_q <= mo_acc_q;
                ro_q <= ro_acc_q;
            end
        end
    end

    assign o_MO        = mo_q;
    assign o_RO        = ro_q;
    assign o_MO_SAMPLE = smp_q;
    assign o_RO_SAMPLE = smp_q;

    // stored-only register bits with no effect on the reduced datapath
    logic unused_bits;
    assign unused_bits = ^{patch_q, test_q[6:0], ctl_q};

endmodule

// File: tb/tb_ikaopll_lite.sv
`timescale 1ns/1ps
module tb_ikaopll_lite;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              ic;
    logic              alt;
    logic              pcen_n;
    logic              xout;
    logic              mos;
    logic              ros;
    logic signed [8:0] mo;
    logic signed [8:0] ro;
    int unsigned       div_q = 0;

    ikaopll_lite_if bus_if();

    ikaopll_lite dut (
        .i_XIN_EMUCLK (clk),
        .i_IC         (ic),
        .o_XOUT       (xout),
        .i_phiM_PCEN_n(pcen_n),
        .i_ALTPATCH_EN(alt),
        .bus          (bus_if),
        .o_MO         (mo),
        .o_RO         (ro),
        .o_MO_SAMPLE  (mos),
        .o_RO_SAMPLE  (ros)
    );

    // phiM tick on every 4th clock
    always @(negedge clk) div_q <= (div_q == 3) ? 0 : div_q + 1;
    assign pcen_n = (div_q != 0);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] mreg [256];
    int         mphase [9];
    bit         malt;
    int         pend_a [$];
    int         pend_d [$];
    bit         pend_alt_vld;
    bit         pend_alt;
    int         exp_mo;
    int         exp_ro;

    function automatic bit m_valid(input int a);
        return (a < 8) || (a == 14) || (a == 15) || (a >= 16 && a <= 24) ||
               (a >= 32 && a <= 40) || (a >= 48 && a <= 56);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mreg[i] = 8'h00;
        for (int c = 0; c < 9; c++) mphase[c] = 0;
        pend_a.delete();
        pend_d.delete();
        pend_alt_vld = 0;
        malt = alt;
    endtask

    // one sample frame from the register contents, using plain arithmetic
    task automatic model_frame();
        int rh, r, v20, v30, fnum, blk, key, amp, hr, wave;
        rh = mreg[14];
        r  = (rh >> 5) & 1;
        exp_mo = 0;
        exp_ro = 0;
        for (int c = 0; c < 9; c++) begin
            v20  = mreg[32 + c];
            v30  = mreg[48 + c];
            fnum = mreg[16 + c] + 256 * (v20 & 1);
            blk  = (v20 >> 1) & 7;
            key  = (v20 >> 4) & 1;
            if (r == 1) begin
                if (c == 6) key = key | ((rh >> 4) & 1);
                if (c == 7) key = key | ((rh >> 3) & 1) | (rh & 1);
                if (c == 8) key = key | ((rh >> 2) & 1) | ((rh >> 1) & 1);
            end
            if (key == 1) mphase[c] = (mphase[c] + fnum * (1 << blk)) % 524288;
            amp = (key == 1) ? 15 - (v30 % 16) : 0;
            hr  = (v30 / 16 == 0) ? ((mreg[3] >> 4) & 1) : int'(malt);
            if (mphase[c] >= 262144) wave = (hr == 1) ? 0 : -amp;
            else wave = amp;
            if (r == 1 && c >= 6) exp_ro += wave;
            else exp_mo += wave;
        end
    endtask

    task automatic apply_pending();
        while (pend_a.size() > 0) begin
            int a, d;
            a = pend_a.pop_front();
            d = pend_d.pop_front();
            if (m_valid(a)) mreg[a] = 8'(d);
        end
        if (pend_alt_vld) begin
            malt = pend_alt;
            pend_alt_vld = 0;
        end
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (mos) begin
                ok = 1;
                break;
            end
        end
    endtask

    // wait for the next published sample and compare it with the model
    task automatic next_frame();
        bit ok;
        wait_strobe(ok);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL strobe_timeout: got no strobe within 400 clocks, required one");
        end else begin
            model_frame();
            chk("frame_mo", int'(mo), exp_mo);
            chk("frame_ro", int'(ro), exp_ro);
            chk("frame_ro_strobe", int'(ros), 1);
        end
        apply_pending();
    endtask

    task automatic bus_cycle(input bit a0, input logic [7:0] d);
        bus_if.i_A0   = a0;
        bus_if.i_D    = d;
        bus_if.i_CS_n = 1'b0;
        bus_if.i_WR_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bus_if.i_CS_n = 1'b1;
        bus_if.i_WR_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    // register write placed after the channel slots of a frame
    task automatic wr_sync(input logic [7:0] a, input logic [7:0] d);
        next_frame();
        repeat (48) @(posedge clk);
        #1;
        bus_cycle(1'b0, a);
        bus_cycle(1'b1, d);
        pend_a.push_back(int'(a));
        pend_d.push_back(int'(d));
    endtask

    task automatic set_alt(input bit v);
        next_frame();
        repeat (48) @(posedge clk);
        #1;
        alt = v;
        pend_alt_vld = 1;
        pend_alt = v;
    endtask

    task automatic do_reset(input int n);
        ic = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        ic = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         mo;
        int         ro;
    } vec_t;

    vec_t tbl [40];
    int   nvec = 0;

    task automatic add_vec(input logic [7:0] a, input logic [7:0] d, input int emo, input int ero);
        tbl[nvec] = '{a, d, emo, ero};
        nvec++;
    endtask

    initial begin
        int ticks;
        int clks;
        bit ok;

        bus_if.i_CS_n = 1'b1;
        bus_if.i_WR_n = 1'b1;
        bus_if.i_A0   = 1'b0;
        bus_if.i_D    = 8'h00;
        alt = 1'b0;
        ic  = 1'b1;

        add_vec(8'h10, 8'hAC, 0, 0);
        add_vec(8'h30, 8'h0C, 0, 0);
        add_vec(8'h20, 8'h12, 3, 0);
        add_vec(8'h30, 8'h00, 15, 0);
        add_vec(8'h30, 8'h0C, 3, 0);
        add_vec(8'h09, 8'hFF, 3, 0);
        for (int n = 1; n < 9; n++) begin
            add_vec(8'(8'h30 + n), 8'(n * 16 + 12), 3 * n, 0);
            add_vec(8'(8'h10 + n), 8'hAC, 3 * n, 0);
            add_vec(8'(8'h20 + n), 8'h12, 3 * (n + 1), 0);
        end
        add_vec(8'h0E, 8'h3F, 18, 9);
        add_vec(8'h0E, 8'h20, 18, 9);
        add_vec(8'h26, 8'h02, 18, 6);
        add_vec(8'h0E, 8'h30, 18, 9);
        add_vec(8'h0E, 8'h00, 24, 0);
        add_vec(8'h03, 8'h10, 24, 0);

        // long reset: everything idle
        repeat (1300) @(posedge clk);
        #1;
        chk("rst_mo", int'(mo), 0);
        chk("rst_ro", int'(ro), 0);
        chk("rst_mo_strobe", int'(mos), 0);
        chk("rst_ro_strobe", int'(ros), 0);
        chk("rst_d_oe", int'(bus_if.o_D_OE), 0);
        chk("rst_d", int'(bus_if.o_D), 0);
        chk("xout_high_clk", int'(xout), 0);
        @(negedge clk);
        #1;
        chk("xout_low_clk", int'(xout), 1);
        ic = 1'b0;
        model_reset();

        // first strobe on the 72nd tick after release
        ticks = 0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (!pcen_n) ticks++;
            #1;
            if (mos) begin
                ok = 1;
                break;
            end
        end
        chk("first_strobe_seen", int'(ok), 1);
        chk("first_strobe_tick", ticks, 72);

        // strobe period and width
        for (int p = 0; p < 2; p++) begin
            clks = 0;
            ok = 0;
            for (int i = 0; i < 400; i++) begin
                @(posedge clk);
                clks++;
                #1;
                if (clks == 1) chk("strobe_width", int'(mos), 0);
                if (mos) begin
                    ok = 1;
                    break;
                end
            end
            chk("strobe_period", clks, 288);
        end

        // table of register writes and the sample they must produce
        for (int i = 0; i < nvec; i++) begin
            wr_sync(tbl[i].a, tbl[i].d);
            next_frame();
            next_frame();
            chk($sformatf("tbl%0d_mo", i), int'(mo), tbl[i].mo);
            chk($sformatf("tbl%0d_ro", i), int'(ro), tbl[i].ro);
        end

        // reset arriving in the middle of a strobed write
        bus_if.i_A0   = 1'b1;
        bus_if.i_D    = 8'hFF;
        bus_if.i_CS_n = 1'b0;
        bus_if.i_WR_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        ic = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus_if.i_CS_n = 1'b1;
        bus_if.i_WR_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        ic = 1'b0;
        model_reset();
        for (int f = 0; f < 3; f++) begin
            next_frame();
            chk("midwr_mo", int'(mo), 0);
            chk("midwr_ro", int'(ro), 0);
        end

        // fast phase: sign flip, wrap, then half-rectify
        do_reset(20);
        wr_sync(8'h10, 8'hFF);
        wr_sync(8'h30, 8'h00);
        wr_sync(8'h20, 8'h1F);
        for (int f = 0; f < 10; f++) next_frame();
        wr_sync(8'h03, 8'h10);
        for (int f = 0; f < 8; f++) next_frame();

        // randomized register traffic against the model
        do_reset(20);
        for (int it = 0; it < 50; it++) begin
            int sel, c;
            logic [7:0] a, d;
            sel = int'($urandom_range(0, 9));
            c   = int'($urandom_range(0, 8));
            d   = 8'($urandom);
            case (sel)
                0, 1, 2: a = 8'(8'h10 + c);
                3, 4: begin
                    a = 8'(8'h20 + c);
                    d = 8'((d & 8'h2F) | (($urandom_range(0, 3) != 0) ? 8'h10 : 8'h00));
                end
                5:       a = 8'(8'h30 + c);
                6:       a = 8'h0E;
                7:       a = 8'h03;
                8: begin
                    case ($urandom_range(0, 3))
                        0:       a = 8'(8'h08 + $urandom_range(0, 5));
                        1:       a = 8'(8'h19 + $urandom_range(0, 6));
                        2:       a = 8'(8'h29 + $urandom_range(0, 6));
                        default: a = 8'($urandom_range(8'h39, 8'hFF));
                    endcase
                end
                default: a = 8'h0F;
            endcase
            if (sel == 9 && ($urandom_range(0, 1) == 1)) set_alt(bit'($urandom_range(0, 1)));
            else wr_sync(a, d);
        end
        next_frame();
        next_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
